// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory line buses around the arbiter.
// The arbiter sits on the slave modport; the caches and memory model use master.
interface mem_arbiter_if #(
  parameter int LINE_W = 256
);
  logic              icache_pmem_read;
  logic [31:0]       icache_pmem_addr;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [31:0]       dcache_pmem_addr;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_addr,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_pmem_read, icache_pmem_addr,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester physical-memory arbiter (icache / dcache) with alternating
// priority on contention and a sticky timeout flag for stalled grants.
module mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          arb_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             arb_err_reg, arb_err_next;

  logic i_req;
  logic d_req;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  // Read data is broadcast; only the resp strobe tells a cache it is valid.
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;
  assign arb_err = arb_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= LAST_I;
      cnt_reg        <= '0;
      arb_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      arb_err_reg    <= arb_err_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    last_grant_next      = last_grant_reg;
    cnt_next             = cnt_reg;
    arb_err_next         = arb_err_reg;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_addr        = '0;
    bus.pmem_wdata       = '0;
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // On contention the side that lost last time wins this time.
        if (i_req && d_req) begin
          if (last_grant_reg == LAST_I) begin
            state_next      = GRANT_D;
            last_grant_next = LAST_D;
          end else begin
            state_next      = GRANT_I;
            last_grant_next = LAST_I;
          end
        end else if (i_req) begin
          state_next      = GRANT_I;
          last_grant_next = LAST_I;
        end else if (d_req) begin
          state_next      = GRANT_D;
          last_grant_next = LAST_D;
        end
      end

      GRANT_I: begin
        bus.pmem_read        = bus.icache_pmem_read;
        bus.pmem_addr        = bus.icache_pmem_addr;
        bus.icache_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      GRANT_D: begin
        bus.pmem_read        = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        bus.pmem_write       = bus.dcache_pmem_write;
        bus.pmem_addr        = bus.dcache_pmem_addr;
        bus.pmem_wdata       = bus.dcache_pmem_wdata;
        bus.dcache_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The flag only reports a stall; the grant is never aborted.
    if (state_reg != IDLE && cnt_next == CNT_MAX) begin
      arb_err_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences
// for the timeout flag and asynchronous reset during a grant.
module tb_mem_arbiter;

  localparam int LINE_W = 256;

  logic clk;
  logic rst;
  logic arb_err;

  mem_arbiter_if #(.LINE_W(LINE_W)) bus ();

  mem_arbiter #(
    .LINE_W (LINE_W),
    .TIMEOUT(255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_v;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        pr;
    logic        erd;
    logic        ewr;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic        eir;
    logic        edr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst_v, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dwd, input logic pr,
                              input logic erd, input logic ewr, input logic [31:0] eaddr,
                              input logic [31:0] ewd, input logic eir, input logic edr);
    vec_t v;
    v.rst_v = rst_v; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.pr = pr; v.erd = erd; v.ewr = ewr; v.eaddr = eaddr;
    v.ewd = ewd; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic pr, input logic [31:0] prd);
    bus.icache_pmem_read  = ir;
    bus.icache_pmem_addr  = ia;
    bus.dcache_pmem_read  = dr;
    bus.dcache_pmem_write = dw;
    bus.dcache_pmem_addr  = da;
    bus.dcache_pmem_wdata = LINE_W'(dwd);
    bus.pmem_resp         = pr;
    bus.pmem_rdata        = LINE_W'(prd);
  endtask

  vec_t vecs[25];

  initial begin
    // Each row is one clock cycle: inputs applied, combinational outputs checked.
    //            rst ir ia       dr dw da       dwd      pr  rd wr addr     wd       ir dr
    vecs[0]  = mk(1, 0, 32'h000, 0, 0, 32'h000, 32'h00, 1,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[1]  = mk(1, 0, 32'h000, 0, 0, 32'h000, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[2]  = mk(1, 1, 32'h040, 0, 0, 32'h000, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[3]  = mk(1, 1, 32'h040, 0, 0, 32'h000, 32'h00, 0,  1, 0, 32'h040, 32'h00, 0, 0);
    vecs[4]  = mk(1, 1, 32'h040, 0, 0, 32'h000, 32'h00, 0,  1, 0, 32'h040, 32'h00, 0, 0);
    vecs[5]  = mk(1, 1, 32'h040, 0, 0, 32'h000, 32'h00, 0,  1, 0, 32'h040, 32'h00, 0, 0);
    vecs[6]  = mk(1, 1, 32'h040, 0, 0, 32'h000, 32'h00, 1,  1, 0, 32'h040, 32'h00, 1, 0);
    vecs[7]  = mk(0, 0, 32'h000, 0, 0, 32'h000, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[8]  = mk(1, 1, 32'h100, 0, 1, 32'h200, 32'hAA, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[9]  = mk(1, 1, 32'h100, 0, 1, 32'h200, 32'hAA, 0,  0, 1, 32'h200, 32'hAA, 0, 0);
    vecs[10] = mk(1, 1, 32'h100, 0, 1, 32'h200, 32'hAA, 1,  0, 1, 32'h200, 32'hAA, 0, 1);
    vecs[11] = mk(1, 1, 32'h100, 0, 0, 32'h000, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[12] = mk(1, 1, 32'h100, 0, 0, 32'h000, 32'h00, 1,  1, 0, 32'h100, 32'h00, 1, 0);
    vecs[13] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[14] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 1,  1, 0, 32'h400, 32'hBB, 0, 1);
    vecs[15] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[16] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 1,  1, 0, 32'h300, 32'h00, 1, 0);
    vecs[17] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[18] = mk(1, 1, 32'h300, 1, 1, 32'h400, 32'hBB, 1,  0, 1, 32'h400, 32'hBB, 0, 1);
    vecs[19] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[20] = mk(1, 1, 32'h300, 1, 0, 32'h400, 32'hBB, 1,  1, 0, 32'h300, 32'h00, 1, 0);
    vecs[21] = mk(1, 0, 32'h000, 1, 0, 32'h500, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);
    vecs[22] = mk(1, 0, 32'h000, 0, 0, 32'h500, 32'h00, 0,  0, 0, 32'h500, 32'h00, 0, 0);
    vecs[23] = mk(1, 0, 32'h000, 0, 0, 32'h500, 32'h00, 1,  0, 0, 32'h500, 32'h00, 0, 1);
    vecs[24] = mk(1, 0, 32'h000, 0, 0, 32'h000, 32'h00, 0,  0, 0, 32'h000, 32'h00, 0, 0);

    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read", 0, LINE_W'(bus.pmem_read), '0);
    chk("rst_pmem_write", 0, LINE_W'(bus.pmem_write), '0);
    chk("rst_pmem_addr", 0, LINE_W'(bus.pmem_addr), '0);
    chk("rst_arb_err", 0, LINE_W'(arb_err), '0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] prd;
      prd = 32'hC0DE_0000 + 32'(i);
      rst = vecs[i].rst_v;
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da,
            vecs[i].dwd, vecs[i].pr, prd);
      #1;
      chk("pmem_read", i, LINE_W'(bus.pmem_read), LINE_W'(vecs[i].erd));
      chk("pmem_write", i, LINE_W'(bus.pmem_write), LINE_W'(vecs[i].ewr));
      chk("pmem_addr", i, LINE_W'(bus.pmem_addr), LINE_W'(vecs[i].eaddr));
      chk("pmem_wdata", i, bus.pmem_wdata, LINE_W'(vecs[i].ewd));
      chk("icache_resp", i, LINE_W'(bus.icache_pmem_resp), LINE_W'(vecs[i].eir));
      chk("dcache_resp", i, LINE_W'(bus.dcache_pmem_resp), LINE_W'(vecs[i].edr));
      chk("icache_rdata", i, bus.icache_pmem_rdata, LINE_W'(prd));
      chk("dcache_rdata", i, bus.dcache_pmem_rdata, LINE_W'(prd));
      chk("arb_err", i, LINE_W'(arb_err), '0);
      $display("vec %0d rst=%0b ir=%0b dr=%0b dw=%0b pr=%0b -> rd=%0b wr=%0b addr=%0h iresp=%0b dresp=%0b",
               i, vecs[i].rst_v, vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].pr,
               bus.pmem_read, bus.pmem_write, bus.pmem_addr,
               bus.icache_pmem_resp, bus.dcache_pmem_resp);
      @(posedge clk);
      #1;
    end

    // Stalled dcache read: flag rises on the 255th grant cycle and sticks.
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 32'h0, 1, 0, 32'h600, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("to_granted", 0, LINE_W'(bus.pmem_read), LINE_W'(1'b1));
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      #1;
      if (k == 254) chk("to_err_before", k, LINE_W'(arb_err), '0);
      if (k == 255) begin
        chk("to_err_set", k, LINE_W'(arb_err), LINE_W'(1'b1));
        chk("to_still_grant", k, LINE_W'(bus.pmem_addr), LINE_W'(32'h600));
      end
    end
    $display("timeout: 255 stalled grant cycles, arb_err=%0b", arb_err);
    bus.pmem_resp = 1'b1;
    #1;
    chk("to_late_resp", 0, LINE_W'(bus.dcache_pmem_resp), LINE_W'(1'b1));
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("to_idle", 0, LINE_W'(bus.pmem_read), '0);
    @(posedge clk);
    #1;
    chk("to_err_sticky", 0, LINE_W'(arb_err), LINE_W'(1'b1));
    rst = 1'b0;
    #1;
    chk("to_err_cleared", 0, LINE_W'(arb_err), '0);
    $display("timeout: after late resp arb_err held, cleared by rst -> %0b", arb_err);

    // Asynchronous reset in the middle of a GRANT_I cycle.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 32'h700, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("ar_granted", 0, LINE_W'(bus.pmem_read), LINE_W'(1'b1));
    #3;
    rst = 1'b0;
    #1;
    chk("ar_read_drop", 0, LINE_W'(bus.pmem_read), '0);
    chk("ar_addr_zero", 0, LINE_W'(bus.pmem_addr), '0);
    chk("ar_err", 0, LINE_W'(arb_err), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_idle", 0, LINE_W'(bus.pmem_read), '0);
    @(posedge clk);
    #1;
    chk("ar_resume", 0, LINE_W'(bus.pmem_addr), LINE_W'(32'h700));
    chk("ar_resume_rd", 0, LINE_W'(bus.pmem_read), LINE_W'(1'b1));
    $display("async reset: grant abandoned, resumed to addr=%0h", bus.pmem_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
